// File: rtl/berger_scrub_memory.sv
// Berger-coded (zero-count) protected memory with a background scrubber,
// a saturating error log and read-path unidirectional fault injection.
// Detect-only: corrupted words are reported, never corrected or rewritten.
module berger_scrub_memory #(
   parameter int DATA_W         = 8,
   parameter int ADDR_W         = 4,
   parameter int SCRUB_INTERVAL = 256,
   localparam int CHECK_W       = $clog2(DATA_W + 1),
   localparam int CW            = DATA_W + CHECK_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] input_addr,
   input  logic [DATA_W-1:0] input_data,
   input  logic [CW-1:0]     fault_mask,
   input  logic              fault_enable,
   input  logic              fault_zero_to_one,
   input  logic              scrub_en,
   input  logic              clear_errors,
   output logic [DATA_W-1:0] output_data,
   output logic              rd_valid,
   output logic              error_detected,
   output logic              scrub_busy,
   output logic              scrub_done,
   output logic [7:0]        err_count,
   output logic [ADDR_W-1:0] err_addr,
   output logic              err_from_scrub
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CNT_W = $clog2(SCRUB_INTERVAL);
   localparam logic [CW-1:0] INIT_WORD = {{DATA_W{1'b0}}, CHECK_W'(DATA_W)};

   typedef enum logic {S_WAIT, S_SCAN} state_t;

   // Berger check symbol: number of zero bits in the data field.
   function automatic logic [CHECK_W-1:0] count_zeros(input logic [DATA_W-1:0] d);
      logic [CHECK_W-1:0] n;
      n = '0;
      for (int i = 0; i < DATA_W; i++) begin
         n = n + {{(CHECK_W-1){1'b0}}, ~d[i]};
      end
      return n;
   endfunction

   logic [CW-1:0]      mem_q [DEPTH];
   logic [CW-1:0]      rd_word_q;
   logic [CW-1:0]      wr_word;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]  scrub_addr_q, scrub_addr_d;
   logic               scrub_issue;

   logic               user_rd;
   logic [ADDR_W-1:0]  rd_sel_addr;
   logic               rd_pend_q, rd_pend_d;
   logic               rd_scrub_q, rd_scrub_d;
   logic               rd_last_q, rd_last_d;
   logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;

   logic [CW-1:0]      fault_word;
   logic [DATA_W-1:0]  eval_data;
   logic               eval_err;

   logic [DATA_W-1:0]  out_hold_q, out_hold_d;
   logic [7:0]         err_count_q, err_count_d;
   logic [ADDR_W-1:0]  err_addr_q, err_addr_d;
   logic               err_src_q, err_src_d;

   // Scrubber state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_WAIT;
         cnt_q        <= '0;
         scrub_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         scrub_addr_q <= scrub_addr_d;
      end
   end

   // Scrubber next state: interval timer in S_WAIT, address walk in S_SCAN.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      scrub_addr_d = scrub_addr_q;
      case (state_q)
         S_WAIT: begin
            if (!scrub_en) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_W'(SCRUB_INTERVAL - 1)) begin
               cnt_d        = '0;
               scrub_addr_d = '0;
               state_d      = S_SCAN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            if (!scrub_en) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end else if (scrub_issue) begin
               scrub_addr_d = scrub_addr_q + 1'b1;
               if (scrub_addr_q == {ADDR_W{1'b1}}) state_d = S_WAIT;
            end
         end
      endcase
   end

   // Scrubber outputs: a scrub read only takes an otherwise idle array cycle.
   always_comb begin
      scrub_busy  = (state_q == S_SCAN);
      scrub_issue = (state_q == S_SCAN) && scrub_en && !wr_en && !rd_en;
   end

   // Array port arbitration and read-issue bookkeeping.
   always_comb begin
      user_rd     = rd_en && !wr_en;
      rd_sel_addr = user_rd ? input_addr : scrub_addr_q;
      wr_word     = {input_data, count_zeros(input_data)};
      rd_pend_d   = user_rd || scrub_issue;
      rd_scrub_d  = scrub_issue;
      rd_last_d   = scrub_issue && (scrub_addr_q == {ADDR_W{1'b1}});
      rd_addr_d   = rd_sel_addr;
   end

   // Storage array with write port, registered read and reset re-initialisation.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= INIT_WORD;
         rd_word_q <= INIT_WORD;
      end else begin
         if (wr_en) mem_q[input_addr] <= wr_word;
         if (rd_pend_d) rd_word_q <= mem_q[rd_sel_addr];
      end
   end

   // Read evaluation: inject the fault on the registered codeword, then decode.
   always_comb begin
      if (!fault_enable)          fault_word = rd_word_q;
      else if (fault_zero_to_one) fault_word = rd_word_q | fault_mask;
      else                        fault_word = rd_word_q & ~fault_mask;
      eval_data      = fault_word[CW-1:CHECK_W];
      eval_err       = (count_zeros(eval_data) != fault_word[CHECK_W-1:0]);
      rd_valid       = rd_pend_q && !rd_scrub_q;
      error_detected = rd_valid && eval_err;
      output_data    = rd_valid ? eval_data : out_hold_q;
      scrub_done     = rd_pend_q && rd_scrub_q && rd_last_q;
      out_hold_d     = output_data;
   end

   // Error log: a clear takes effect before an error logged in the same cycle.
   always_comb begin
      err_count_d = clear_errors ? 8'd0 : err_count_q;
      err_addr_d  = clear_errors ? '0 : err_addr_q;
      err_src_d   = clear_errors ? 1'b0 : err_src_q;
      if (rd_pend_q && eval_err) begin
         if (err_count_d != 8'hFF) err_count_d = err_count_d + 8'd1;
         err_addr_d = rd_addr_q;
         err_src_d  = rd_scrub_q;
      end
      err_count      = err_count_q;
      err_addr       = err_addr_q;
      err_from_scrub = err_src_q;
   end

   // Read pipeline, held output and error log registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend_q   <= 1'b0;
         rd_scrub_q  <= 1'b0;
         rd_last_q   <= 1'b0;
         rd_addr_q   <= '0;
         out_hold_q  <= '0;
         err_count_q <= 8'd0;
         err_addr_q  <= '0;
         err_src_q   <= 1'b0;
      end else begin
         rd_pend_q   <= rd_pend_d;
         rd_scrub_q  <= rd_scrub_d;
         rd_last_q   <= rd_last_d;
         rd_addr_q   <= rd_addr_d;
         out_hold_q  <= out_hold_d;
         err_count_q <= err_count_d;
         err_addr_q  <= err_addr_d;
         err_src_q   <= err_src_d;
      end
   end

endmodule

// File: tb/tb_berger_scrub_memory.sv
// Scoreboard bench for berger_scrub_memory (DATA_W=8, ADDR_W=4, SCRUB_INTERVAL=16).
module tb_berger_scrub_memory;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en, rd_en;
   logic [3:0]  input_addr;
   logic [7:0]  input_data;
   logic [11:0] fault_mask;
   logic        fault_enable, fault_zero_to_one;
   logic        scrub_en, clear_errors;
   logic [7:0]  output_data;
   logic        rd_valid, error_detected, scrub_busy, scrub_done;
   logic [7:0]  err_count;
   logic [3:0]  err_addr;
   logic        err_from_scrub;

   typedef struct packed {
      logic [7:0] data;
      logic       err;
   } rd_exp_t;

   rd_exp_t sb_q[$];
   int      n_asserts = 0;
   int      n_fail    = 0;

   always #5 clk = ~clk;

   berger_scrub_memory #(
      .DATA_W(8), .ADDR_W(4), .SCRUB_INTERVAL(16)
   ) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
      .input_addr(input_addr), .input_data(input_data),
      .fault_mask(fault_mask), .fault_enable(fault_enable),
      .fault_zero_to_one(fault_zero_to_one), .scrub_en(scrub_en),
      .clear_errors(clear_errors), .output_data(output_data),
      .rd_valid(rd_valid), .error_detected(error_detected),
      .scrub_busy(scrub_busy), .scrub_done(scrub_done),
      .err_count(err_count), .err_addr(err_addr),
      .err_from_scrub(err_from_scrub)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_asserts++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Scoreboard consumer: every rd_valid pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && rd_valid) begin
         if (sb_q.size() == 0) begin
            check_eq("unexpected_rd_valid", 32'(rd_valid), 32'd0);
         end else begin
            rd_exp_t e;
            e = sb_q.pop_front();
            check_eq("rd_data", 32'(output_data), 32'(e.data));
            check_eq("rd_err", 32'(error_detected), 32'(e.err));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [3:0] a, input logic [7:0] d);
      input_addr = a; input_data = d; wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
   endtask

   // Issue a read, hold fault inputs through evaluation, then let the log settle.
   task automatic do_read(input logic [3:0] a, input logic [7:0] ed, input logic ee);
      rd_exp_t e;
      e.data = ed; e.err = ee;
      sb_q.push_back(e);
      input_addr = a; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      tick();
   endtask

   // One scrub pass; optional user read stalls it at scan cycle stall_at.
   task automatic run_pass(input int stall_at, input int exp_lat, input string tag);
      int  k;
      int  busy_n;
      bit  started;
      bit  done;
      rd_exp_t e;
      k = 0; busy_n = 0; started = 0; done = 0;
      scrub_en = 1'b1;
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge clk);
         if (scrub_busy) started = 1;
         if (started) begin
            if (scrub_busy) busy_n++;
            if (k == stall_at) begin
               e.data = 8'h00; e.err = 1'b0;
               sb_q.push_back(e);
               input_addr = 4'd2; rd_en = 1'b1;
            end
            if (k == stall_at + 1) rd_en = 1'b0;
            if (scrub_done) begin
               done = 1;
               check_eq({tag, "_done_lat"}, 32'(k), 32'(exp_lat));
               check_eq({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat));
            end
            k++;
         end
      end
      if (!done) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
      scrub_en = 1'b0;
      @(negedge clk);
      check_eq({tag, "_done_single"}, 32'(scrub_done), 32'd0);
      check_eq({tag, "_busy_end"}, 32'(scrub_busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; input_addr = '0; input_data = '0;
      fault_mask = '0; fault_enable = 1'b0; fault_zero_to_one = 1'b0;
      scrub_en = 1'b0; clear_errors = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
      check_eq("rst_output_data", 32'(output_data), 32'd0);
      check_eq("rst_err_count", 32'(err_count), 32'd0);
      check_eq("rst_scrub_busy", 32'(scrub_busy), 32'd0);
      check_eq("rst_scrub_done", 32'(scrub_done), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Fresh array reads as data 0 with a consistent check field.
      do_read(4'd3, 8'h00, 1'b0);
      check_eq("err_count_after_clean", 32'(err_count), 32'd0);

      // Write then read back.
      do_write(4'd5, 8'hA5);
      do_read(4'd5, 8'hA5, 1'b0);

      // 0->1 on data bit 1.
      fault_enable = 1'b1; fault_zero_to_one = 1'b1; fault_mask = 12'h020;
      do_read(4'd5, 8'hA7, 1'b1);
      check_eq("log_count_1", 32'(err_count), 32'd1);
      check_eq("log_addr_1", 32'(err_addr), 32'd5);
      check_eq("log_src_1", 32'(err_from_scrub), 32'd0);

      // 1->0 on check bit 2.
      fault_zero_to_one = 1'b0; fault_mask = 12'h004;
      do_read(4'd5, 8'hA5, 1'b1);
      fault_enable = 1'b0;
      check_eq("log_count_2", 32'(err_count), 32'd2);

      // Simultaneous write and read: write wins, no rd_valid.
      input_addr = 4'd7; input_data = 8'h3C; wr_en = 1'b1; rd_en = 1'b1;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      @(negedge clk);
      check_eq("wr_rd_no_valid", 32'(rd_valid), 32'd0);
      tick();
      do_read(4'd7, 8'h3C, 1'b0);
      check_eq("hold_output", 32'(output_data), 32'h3C);

      // Re-initialise, then one full scrub pass with a persistent fault.
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check_eq("rst2_err_count", 32'(err_count), 32'd0);
      fault_enable = 1'b1; fault_zero_to_one = 1'b1; fault_mask = 12'h010;
      run_pass(-1, 16, "scan1");
      check_eq("scan1_count", 32'(err_count), 32'd16);
      check_eq("scan1_addr", 32'(err_addr), 32'd15);
      check_eq("scan1_src", 32'(err_from_scrub), 32'd1);

      // Fault off, one user read mid-scan stalls the pass by one cycle.
      fault_enable = 1'b0;
      run_pass(5, 17, "scan_stall");
      check_eq("scan_stall_count", 32'(err_count), 32'd16);

      // Drive well past 255 errors.
      fault_enable = 1'b1;
      for (int p = 0; p < 16; p++) run_pass(-1, 16, "sat_pass");
      check_eq("sat_count", 32'(err_count), 32'd255);

      // Clear together with a new error: clear first, then log it.
      tick();
      begin
         rd_exp_t e;
         e.data = 8'h01; e.err = 1'b1;
         sb_q.push_back(e);
      end
      input_addr = 4'd9; rd_en = 1'b1;
      tick();
      rd_en = 1'b0; clear_errors = 1'b1;
      tick();
      clear_errors = 1'b0; fault_enable = 1'b0;
      check_eq("clear_err_count", 32'(err_count), 32'd1);
      check_eq("clear_err_addr", 32'(err_addr), 32'd9);
      check_eq("clear_err_src", 32'(err_from_scrub), 32'd0);

      // Plain clear.
      clear_errors = 1'b1;
      tick();
      clear_errors = 1'b0;
      check_eq("clear_only_count", 32'(err_count), 32'd0);
      check_eq("clear_only_addr", 32'(err_addr), 32'd0);

      tick();
      check_eq("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
